// File: rtl/ibex_wb_queue.sv
// ibex_wb_queue: in-order multi-entry writeback queue with load-data merge,
// per-port forwarding and load hazard detection across all queued entries.
module ibex_wb_queue #(
    parameter int unsigned Depth             = 2,
    parameter int unsigned NumRdPorts        = 2,
    parameter bit          DummyInstructions = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_wb_i,
    input  logic [1:0]              instr_type_wb_i,
    input  logic [31:0]             pc_id_i,
    input  logic                    instr_is_compressed_id_i,
    input  logic                    instr_perf_count_id_i,
    input  logic [4:0]              rf_waddr_id_i,
    input  logic [31:0]             rf_wdata_id_i,
    input  logic                    rf_we_id_i,
    input  logic                    dummy_instr_id_i,
    input  logic [31:0]             rf_wdata_lsu_i,
    input  logic                    rf_we_lsu_i,
    input  logic                    lsu_resp_valid_i,
    input  logic                    lsu_resp_err_i,
    input  logic [5*NumRdPorts-1:0] rf_raddr_i,
    output logic                    ready_wb_o,
    output logic [4:0]              rf_waddr_wb_o,
    output logic [31:0]             rf_wdata_wb_o,
    output logic                    rf_we_wb_o,
    output logic [31:0]             pc_wb_o,
    output logic                    instr_done_wb_o,
    output logic                    outstanding_load_wb_o,
    output logic                    outstanding_store_wb_o,
    output logic                    perf_instr_ret_wb_o,
    output logic                    perf_instr_ret_compressed_wb_o,
    output logic                    dummy_instr_wb_o,
    output logic [NumRdPorts-1:0]   fwd_hit_o,
    output logic [32*NumRdPorts-1:0] fwd_data_o,
    output logic [NumRdPorts-1:0]   fwd_stall_o,
    output logic [3:0]              occupancy_o
);
    localparam int unsigned PtrW = Depth > 1 ? $clog2(Depth) : 1;

    typedef struct packed {
        logic [1:0]  itype;
        logic [31:0] pc;
        logic        comp;
        logic        cnt;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we;
        logic        dummy;
    } entry_t;

    entry_t           ent_q [Depth];
    entry_t           new_ent, head;
    logic [Depth-1:0] valid_q;
    logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [3:0]       count_q;
    logic             head_valid, head_load, head_other, head_done, full, push, lsu_err;

    function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign new_ent    = '{instr_type_wb_i, pc_id_i, instr_is_compressed_id_i, instr_perf_count_id_i,
                          rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i, DummyInstructions & dummy_instr_id_i};
    assign head       = ent_q[rd_ptr_q];
    assign head_valid = valid_q[rd_ptr_q];
    assign head_load  = head.itype == 2'd0;
    assign head_other = head.itype == 2'd2;
    // Loads and stores complete only on the LSU response for the oldest memory op.
    assign head_done  = head_valid & (head_other | ((head.itype < 2'd2) & lsu_resp_valid_i));
    assign full       = count_q == 4'(Depth);
    assign ready_wb_o = ~full | head_done;
    assign push       = en_wb_i & ready_wb_o;
    assign lsu_err    = lsu_resp_valid_i & lsu_resp_err_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Clear before set: at full, a retire and enqueue may share one slot.
            if (head_done) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= inc(rd_ptr_q);
            end
            if (push) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= inc(wr_ptr_q);
            end
            count_q <= count_q + 4'(push) - 4'(head_done);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) ent_q[wr_ptr_q] <= new_ent;
    end

    assign rf_waddr_wb_o   = head_valid ? head.waddr : '0;
    assign pc_wb_o         = head_valid ? head.pc : '0;
    assign rf_we_wb_o      = head_done & (head_load ? rf_we_lsu_i : head_other & head.we);
    assign rf_wdata_wb_o   = ~head_valid ? '0 : head_load ? rf_wdata_lsu_i : head.wdata;
    assign instr_done_wb_o = head_done;
    assign perf_instr_ret_wb_o            = head_done & head.cnt & ~lsu_err;
    assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & head.comp;
    assign dummy_instr_wb_o               = DummyInstructions & head_valid & head.dummy;
    assign occupancy_o                    = count_q;

    always_comb begin
        outstanding_load_wb_o  = 1'b0;
        outstanding_store_wb_o = 1'b0;
        for (int i = 0; i < int'(Depth); i++) begin
            outstanding_load_wb_o  |= valid_q[i] & (ent_q[i].itype == 2'd0);
            outstanding_store_wb_o |= valid_q[i] & (ent_q[i].itype == 2'd1);
        end
    end

    // Walk entries oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [PtrW-1:0] idx;
        logic [4:0]      raddr;
        fwd_hit_o   = '0;
        fwd_stall_o = '0;
        fwd_data_o  = '0;
        idx         = '0;
        raddr       = '0;
        for (int p = 0; p < int'(NumRdPorts); p++) begin
            raddr = rf_raddr_i[5*p +: 5];
            idx   = rd_ptr_q;
            for (int k = 0; k < int'(Depth); k++) begin
                if (valid_q[idx] && raddr != 5'd0 && ent_q[idx].waddr == raddr &&
                    (ent_q[idx].we || ent_q[idx].itype == 2'd0)) begin
                    fwd_hit_o[p]         = ent_q[idx].itype != 2'd0;
                    fwd_stall_o[p]       = ent_q[idx].itype == 2'd0;
                    fwd_data_o[32*p +: 32] = ent_q[idx].itype == 2'd0 ? '0 : ent_q[idx].wdata;
                end
                idx = inc(idx);
            end
        end
    end
endmodule

// File: tb/tb_ibex_wb_queue.sv
// tb_ibex_wb_queue: directed scenarios plus random traffic checked every cycle
// against a queue-based behavioural model of the writeback queue.
module tb_ibex_wb_queue;
    localparam int DEPTH = 2;
    localparam int NP    = 2;

    logic        clk = 1'b0, rst_i = 1'b1;
    logic        en_wb_i, instr_is_compressed_id_i, instr_perf_count_id_i, rf_we_id_i, dummy_instr_id_i;
    logic [1:0]  instr_type_wb_i;
    logic [31:0] pc_id_i, rf_wdata_id_i, rf_wdata_lsu_i;
    logic [4:0]  rf_waddr_id_i;
    logic        rf_we_lsu_i, lsu_resp_valid_i, lsu_resp_err_i;
    logic [5*NP-1:0] rf_raddr_i;
    logic        ready_wb_o, rf_we_wb_o, instr_done_wb_o, outstanding_load_wb_o, outstanding_store_wb_o;
    logic        perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o, dummy_instr_wb_o;
    logic [4:0]  rf_waddr_wb_o;
    logic [31:0] rf_wdata_wb_o, pc_wb_o;
    logic [NP-1:0]    fwd_hit_o, fwd_stall_o;
    logic [32*NP-1:0] fwd_data_o;
    logic [3:0]  occupancy_o;

    always #5 clk = ~clk;

    ibex_wb_queue #(.Depth(DEPTH), .NumRdPorts(NP), .DummyInstructions(1'b0)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_wb_i(en_wb_i), .instr_type_wb_i(instr_type_wb_i),
        .pc_id_i(pc_id_i), .instr_is_compressed_id_i(instr_is_compressed_id_i),
        .instr_perf_count_id_i(instr_perf_count_id_i), .rf_waddr_id_i(rf_waddr_id_i),
        .rf_wdata_id_i(rf_wdata_id_i), .rf_we_id_i(rf_we_id_i), .dummy_instr_id_i(dummy_instr_id_i),
        .rf_wdata_lsu_i(rf_wdata_lsu_i), .rf_we_lsu_i(rf_we_lsu_i), .lsu_resp_valid_i(lsu_resp_valid_i),
        .lsu_resp_err_i(lsu_resp_err_i), .rf_raddr_i(rf_raddr_i), .ready_wb_o(ready_wb_o),
        .rf_waddr_wb_o(rf_waddr_wb_o), .rf_wdata_wb_o(rf_wdata_wb_o), .rf_we_wb_o(rf_we_wb_o),
        .pc_wb_o(pc_wb_o), .instr_done_wb_o(instr_done_wb_o),
        .outstanding_load_wb_o(outstanding_load_wb_o), .outstanding_store_wb_o(outstanding_store_wb_o),
        .perf_instr_ret_wb_o(perf_instr_ret_wb_o),
        .perf_instr_ret_compressed_wb_o(perf_instr_ret_compressed_wb_o),
        .dummy_instr_wb_o(dummy_instr_wb_o), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
        .fwd_stall_o(fwd_stall_o), .occupancy_o(occupancy_o)
    );

    typedef struct {
        int          t;
        logic [31:0] pc;
        bit          comp;
        bit          cnt;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        bit          we;
    } ent_t;

    ent_t q[$];
    int   checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_done();
        return q.size() > 0 && (q[0].t == 2 || lsu_resp_valid_i);
    endfunction

    task automatic compare();
        ent_t        h;
        bit          done, ewe, perf, ol, os, eh, es;
        logic [31:0] ed;
        logic [4:0]  ra;
        if (rst_i) q.delete();
        h    = '{0, 0, 0, 0, 0, 0, 0};
        if (q.size() > 0) h = q[0];
        done = model_done();
        ewe  = done && (h.t == 0 ? rf_we_lsu_i : (h.t == 2 && h.we));
        perf = done && h.cnt && !(lsu_resp_valid_i && lsu_resp_err_i);
        chk("ready", 32'(ready_wb_o), 32'(q.size() < DEPTH || done));
        chk("done", 32'(instr_done_wb_o), 32'(done));
        chk("rf_we", 32'(rf_we_wb_o), 32'(ewe));
        if (ewe) chk("rf_wdata", rf_wdata_wb_o, h.t == 0 ? rf_wdata_lsu_i : h.wdata);
        chk("rf_waddr", 32'(rf_waddr_wb_o), 32'(h.waddr));
        chk("pc", pc_wb_o, h.pc);
        chk("perf", 32'(perf_instr_ret_wb_o), 32'(perf));
        chk("perf_c", 32'(perf_instr_ret_compressed_wb_o), 32'(perf && h.comp));
        chk("dummy", 32'(dummy_instr_wb_o), 32'(0));
        chk("occ", 32'(occupancy_o), 32'(q.size()));
        ol = 0;
        os = 0;
        foreach (q[i]) begin
            ol |= q[i].t == 0;
            os |= q[i].t == 1;
        end
        chk("out_load", 32'(outstanding_load_wb_o), 32'(ol));
        chk("out_store", 32'(outstanding_store_wb_o), 32'(os));
        for (int p = 0; p < NP; p++) begin
            ra = rf_raddr_i[5*p +: 5];
            eh = 0;
            es = 0;
            ed = 0;
            foreach (q[i]) if (ra != 0 && q[i].waddr == ra && (q[i].we || q[i].t == 0)) begin
                eh = q[i].t != 0;
                es = q[i].t == 0;
                ed = q[i].wdata;
            end
            chk($sformatf("fwd_hit%0d", p), 32'(fwd_hit_o[p]), 32'(eh));
            chk($sformatf("fwd_stall%0d", p), 32'(fwd_stall_o[p]), 32'(es));
            if (eh) chk($sformatf("fwd_data%0d", p), fwd_data_o[32*p +: 32], ed);
        end
    endtask

    task automatic idle();
        en_wb_i          = 0;
        instr_type_wb_i  = 2'($urandom_range(0, 2));
        pc_id_i          = $urandom;
        instr_is_compressed_id_i = 1'($urandom);
        instr_perf_count_id_i    = 1'($urandom);
        rf_waddr_id_i    = 5'($urandom_range(0, 7));
        rf_wdata_id_i    = $urandom;
        rf_we_id_i       = 1'($urandom);
        dummy_instr_id_i = 0;
        rf_wdata_lsu_i   = $urandom;
        rf_we_lsu_i      = 0;
        lsu_resp_valid_i = 0;
        lsu_resp_err_i   = 0;
        rf_raddr_i       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    endtask

    task automatic enq(input int t, input int wa, input logic [31:0] wd, input bit we, input bit cnt);
        en_wb_i = 1;
        instr_type_wb_i = 2'(t);
        rf_waddr_id_i = 5'(wa);
        rf_wdata_id_i = wd;
        rf_we_id_i = we;
        instr_perf_count_id_i = cnt;
    endtask

    task automatic settle();
        #1 compare();
    endtask

    task automatic tick();
        bit done, rdy;
        @(posedge clk);
        if (!rst_i) begin
            done = model_done();
            rdy  = q.size() < DEPTH || done;
            if (done) void'(q.pop_front());
            if (en_wb_i && rdy)
                q.push_back('{int'(instr_type_wb_i), pc_id_i, instr_is_compressed_id_i,
                              instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i});
        end
        @(negedge clk);
        idle();
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    initial begin
        idle();
        repeat (2) @(negedge clk);
        settle();
        chk("rst_occ", 32'(occupancy_o), 32'd0);
        chk("rst_ready", 32'(ready_wb_o), 32'd1);
        chk("rst_we", 32'(rf_we_wb_o), 32'd0);
        tick();
        rst_i = 0;
        // type2 x5 retires the cycle after enqueue
        enq(2, 5, 32'h11, 1, 1);
        cyc();
        settle();
        chk("t1_we", 32'(rf_we_wb_o), 32'd1);
        chk("t1_addr", 32'(rf_waddr_wb_o), 32'd5);
        chk("t1_data", rf_wdata_wb_o, 32'h11);
        chk("t1_done", 32'(instr_done_wb_o), 32'd1);
        tick();
        settle();
        chk("t1_occ", 32'(occupancy_o), 32'd0);
        tick();
        // load x6 then type2 x7 waiting on a delayed response
        enq(0, 6, 32'h0, 0, 1);
        cyc();
        enq(2, 7, 32'h22, 1, 1);
        cyc();
        repeat (2) begin
            settle();
            chk("t2_wait_done", 32'(instr_done_wb_o), 32'd0);
            chk("t2_out_load", 32'(outstanding_load_wb_o), 32'd1);
            tick();
        end
        lsu_resp_valid_i = 1;
        rf_we_lsu_i = 1;
        rf_wdata_lsu_i = 32'hAB;
        settle();
        chk("t2_ld_we", 32'(rf_we_wb_o), 32'd1);
        chk("t2_ld_addr", 32'(rf_waddr_wb_o), 32'd6);
        chk("t2_ld_data", rf_wdata_wb_o, 32'hAB);
        tick();
        settle();
        chk("t2_x7_addr", 32'(rf_waddr_wb_o), 32'd7);
        chk("t2_x7_data", rf_wdata_wb_o, 32'h22);
        tick();
        // full with loads, then simultaneous retire and enqueue
        enq(0, 1, 0, 0, 1);
        cyc();
        enq(0, 2, 0, 0, 1);
        cyc();
        enq(0, 4, 0, 0, 1);
        settle();
        chk("t3_full_ready", 32'(ready_wb_o), 32'd0);
        chk("t3_full_occ", 32'(occupancy_o), 32'd2);
        tick();
        enq(0, 4, 0, 0, 1);
        lsu_resp_valid_i = 1;
        rf_we_lsu_i = 1;
        settle();
        chk("t3_ready", 32'(ready_wb_o), 32'd1);
        tick();
        settle();
        chk("t3_occ", 32'(occupancy_o), 32'd2);
        tick();
        repeat (2) begin
            lsu_resp_valid_i = 1;
            cyc();
        end
        // forwarding: non-load hit, load stall, youngest load wins
        enq(0, 9, 0, 0, 1);
        cyc();
        enq(2, 3, 32'h5, 1, 1);
        cyc();
        rf_raddr_i = {5'd9, 5'd3};
        settle();
        chk("t4_hit0", 32'(fwd_hit_o[0]), 32'd1);
        chk("t4_data0", fwd_data_o[31:0], 32'h5);
        chk("t4_stall1", 32'(fwd_stall_o[1]), 32'd1);
        tick();
        lsu_resp_valid_i = 1;
        enq(0, 3, 0, 0, 1);
        cyc();
        rf_raddr_i = {5'd0, 5'd3};
        settle();
        chk("t4_stall0", 32'(fwd_stall_o[0]), 32'd1);
        chk("t4_nohit0", 32'(fwd_hit_o[0]), 32'd0);
        chk("t4_x0", 32'({fwd_hit_o[1], fwd_stall_o[1]}), 32'd0);
        tick();
        lsu_resp_valid_i = 1;
        cyc();
        // erroring load: no RF write, not counted
        enq(0, 8, 0, 0, 1);
        cyc();
        lsu_resp_valid_i = 1;
        lsu_resp_err_i = 1;
        settle();
        chk("t5_done", 32'(instr_done_wb_o), 32'd1);
        chk("t5_we", 32'(rf_we_wb_o), 32'd0);
        chk("t5_perf", 32'(perf_instr_ret_wb_o), 32'd0);
        tick();
        // reset with two entries queued
        enq(0, 10, 0, 0, 1);
        cyc();
        enq(0, 11, 0, 0, 1);
        cyc();
        rst_i = 1;
        settle();
        chk("t6_occ", 32'(occupancy_o), 32'd0);
        chk("t6_ready", 32'(ready_wb_o), 32'd1);
        tick();
        rst_i = 0;
        repeat (3) begin
            lsu_resp_valid_i = 1;
            rf_we_lsu_i = 1;
            settle();
            chk("t6_no_we", 32'(rf_we_wb_o), 32'd0);
            tick();
        end
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst_i = ($urandom_range(0, 99) == 0);
            en_wb_i = ($urandom_range(0, 9) < 6);
            lsu_resp_valid_i = ($urandom_range(0, 9) < 4);
            lsu_resp_err_i = ($urandom_range(0, 4) == 0);
            rf_we_lsu_i = 1'($urandom);
            cyc();
        end
        rst_i = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
